// File: rtl/mac_feeder.sv
// Operand FIFO feeding a start/finish handshaked MAC unit, with a held result
// register, a bounded wait for completion and a sticky timeout flag.
module mac_feeder #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_a,
  input  logic [7:0]               in_b,
  output logic                     mac_start,
  output logic [7:0]               mac_op_a,
  output logic [7:0]               mac_op_b,
  input  logic                     mac_finish,
  input  logic [19:0]              mac_rc,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [19:0]              res_data,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [AW:0]   LvlFull  = DEPTH[AW:0];
  localparam logic [CW-1:0] CntLast  = CW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]    op_a_q, op_a_d, op_b_q, op_b_d;
  logic [19:0]   res_data_q, res_data_d;
  logic          timeout_err_q, timeout_err_d;

  logic push, pop;

  assign in_ready = (level_q != LvlFull);
  assign push     = in_valid & in_ready;
  // The FSM consumes the head entry only while idle; ISSUE follows on the same edge.
  assign pop      = (state_q == IDLE) && (level_q != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_a, in_b};
    end
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    res_data_d    = res_data_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          {op_a_d, op_b_d} = mem_q[rd_ptr_q];
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        // Any finish seen here predates our start request and is ignored.
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (mac_finish) begin
          res_data_d = mac_rc;
          state_d    = HOLD;
        end else if (wait_cnt_q == CntLast) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      res_data_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      res_data_q    <= res_data_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign mac_start   = (state_q == ISSUE) || (state_q == WAIT);
  assign res_valid   = (state_q == HOLD);
  assign busy        = (state_q != IDLE);
  assign mac_op_a    = op_a_q;
  assign mac_op_b    = op_b_q;
  assign res_data    = res_data_q;
  assign timeout_err = timeout_err_q;
  assign level       = level_q;

endmodule

// File: doc/mac_feeder.md
MAC_FEEDER -- requirements
Module: mac_feeder

Parameters
REQ-001 The block SHALL provide parameter DEPTH, default 4, setting the operand FIFO entry count (power of two, 2..16).
REQ-002 The block SHALL provide parameter TIMEOUT, default 64, setting the maximum cycles spent waiting for mac_finish.

Interface
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  an upstream operand pair is offered.
REQ-006 in_ready  output  1  the FIFO can accept a pair.
REQ-007 in_a, in_b  input  8 each  operand pair, unsigned.
REQ-008 mac_start  output  1  start request level to the MAC unit.
REQ-009 mac_op_a, mac_op_b  output  8 each  operands driven to the MAC unit.
REQ-010 mac_finish  input  1  MAC unit completion flag.
REQ-011 mac_rc  input  20  MAC unit accumulated result.
REQ-012 res_valid  output  1  a captured result is available.
REQ-013 res_ready  input  1  downstream accepts the result.
REQ-014 res_data  output  20  captured result.
REQ-015 busy  output  1  FSM is not in IDLE.
REQ-016 timeout_err  output  1  sticky flag for a MAC timeout.
REQ-017 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-018 FIFO push SHALL occur on a clock edge where in_valid=1 and in_ready=1, with in_ready = (level != DEPTH).
REQ-019 Pointers SHALL wrap modulo DEPTH, and entries SHALL leave the FIFO in arrival order.
REQ-020 A push and a pop on the same edge SHALL leave level unchanged, and both operations SHALL take effect.
REQ-021 The FSM SHALL have four states: IDLE, ISSUE, WAIT, HOLD.
REQ-022 In IDLE with level>0, the FSM SHALL pop the head entry into the mac_op_a/mac_op_b registers and move to ISSUE on that same edge.
REQ-023 In ISSUE, the FSM SHALL drive mac_start=1, clear the wait counter, and move to WAIT after 1 cycle.
REQ-024 In WAIT, mac_start SHALL stay 1 and mac_op_a/b SHALL stay stable.
REQ-025 In WAIT, on mac_finish=1 the FSM SHALL capture mac_rc into res_data, drop mac_start, and move to HOLD.
REQ-026 In WAIT, if the wait counter reaches TIMEOUT without mac_finish, the FSM SHALL set timeout_err, drop mac_start, discard the pair, and return to IDLE without raising res_valid.
REQ-027 mac_finish seen in ISSUE SHALL be ignored, because the MAC has not yet observed start.
REQ-028 In HOLD, res_valid SHALL be 1 and res_data SHALL be held stable until res_ready=1, after which the FSM returns to IDLE.
REQ-029 mac_finish SHALL be ignored in IDLE and HOLD.
REQ-030 Minimum pair-to-pair issue spacing SHALL be ISSUE + WAIT(>=1) + HOLD(>=1) + IDLE = 4 cycles.
REQ-031 Latency from the accepting edge to mac_start=1 SHALL be 2 cycles when the FSM is idle and the FIFO is empty.
REQ-032 busy SHALL be 1 in ISSUE, WAIT and HOLD.
REQ-033 res_data SHALL be a straight 20-bit copy of mac_rc, with no truncation or extension.

Reset
REQ-034 While rst=1, asynchronously, the FSM SHALL be in IDLE, the FIFO pointers and level SHALL be 0, and the wait counter SHALL be 0.
REQ-035 While rst=1, mac_start=0, mac_op_a=0, mac_op_b=0, res_valid=0, res_data=0 and timeout_err=0.
REQ-036 While rst=1, in_ready SHALL be 1.
REQ-037 Reset asserted mid-operation, including in WAIT or HOLD, SHALL discard all FIFO contents and the in-flight pair.
REQ-038 timeout_err SHALL clear only on reset.

Verification
REQ-039 Single pair: push (10,10) into an idle block, MAC model returns finish 3 cycles after start with rc=100 -> mac_start high 2 cycles after push, mac_op_a=mac_op_b=10, res_valid=1 with res_data=100.
REQ-040 Back-to-back: push (255,255), (3,4), (4,2), (8,10) with res_ready tied high -> results 65025, 12, 8, 80 delivered in order, at least 4 cycles apart.
REQ-041 Full FIFO: stall finish while pushing DEPTH+1 pairs -> in_ready=0 once level=DEPTH, the extra pair is not accepted, and no entry is lost or duplicated.
REQ-042 Backpressure: hold res_ready=0 for 10 cycles in HOLD -> res_valid and res_data stable, no pop, mac_start=0 throughout.
REQ-043 Timeout: never assert finish -> timeout_err=1 exactly TIMEOUT cycles into WAIT, no res_valid, and the next pair issues normally.
REQ-044 Reset in WAIT with 2 pairs queued -> all outputs at reset values immediately, level=0, and no result is produced after release.
